interpreter: RTL

Readout stage of the integer echo state network. The sequencer FSM raises its interpreter-enable after each reservoir update. On that enable this block reads N reservoir states and N output weights and accumulates their dot product in N MAC cycles. It then presents a scaled, saturated result with a one-cycle ready pulse, which the sequencer consumes as its interpreter-ready input to start the next reservoir step.

---
 rtl/interpreter_pkg.sv | 30 +++
 rtl/interpreter_mac.sv | 37 +++
 rtl/interpreter.sv | 109 ++++++++++
 3 files changed

// File: rtl/interpreter_pkg.sv
// Shared ESN definitions: FSM encoding, default widths and the signed
// saturation helper used by both the readout and the reservoir.
`timescale 1ns/1ps
package interpreter_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_WW = 8;
    localparam int DEF_OW = 16;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_RUN   = 5'b00010,
        S_DRAIN = 5'b00100,
        S_DONE  = 5'b01000,
        S_REARM = 5'b10000
    } state_e;

    // Clamp v to the range of a w-bit signed number (w <= 63).
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/interpreter_mac.sv
// Signed multiply-accumulate register with synchronous clear and valid enable;
// exposes the next-state value so the caller can use the final sum on its last edge.
`timescale 1ns/1ps
module interpreter_mac #(
    parameter int DW = 8,
    parameter int WW = 8,
    parameter int AW = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 vld_i,
    input  logic signed [DW-1:0] state_i,
    input  logic signed [WW-1:0] weight_i,
    output logic signed [AW-1:0] acc_next_o
);

    localparam int PW = DW + WW;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;

    always_comb begin
        prod  = PW'(state_i) * PW'(weight_i);
        acc_d = vld_i ? acc_q + AW'(prod) : acc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else            acc_q <= acc_d;
    end

    assign acc_next_o = acc_d;

endmodule

// File: rtl/interpreter.sv
// ESN readout: on enable, streams N state/weight pairs through the MAC,
// then emits a shifted, saturated result with a one-cycle ready pulse.
`timescale 1ns/1ps
module interpreter
    import interpreter_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int DW    = DEF_DW,
    parameter  int WW    = DEF_WW,
    parameter  int SHIFT = 0,
    parameter  int OW    = DEF_OW,
    localparam int AW    = DW + WW + $clog2(N),
    localparam int AddrW = $clog2(N)
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iEn,
    output logic [AddrW-1:0]     oAddr,
    input  logic signed [DW-1:0] iState,
    input  logic signed [WW-1:0] iWeight,
    output logic signed [OW-1:0] oY,
    output logic                 oRdy
);

    state_e              state_q;
    logic [AddrW-1:0]    addr_q;
    logic                iss_q;
    logic                vld_q;
    logic                armed_q;
    logic signed [OW-1:0] y_q;
    logic                rdy_q;
    logic                clr;
    logic signed [AW-1:0] acc_next;

    assign clr = (state_q == S_IDLE) && iEn && armed_q;

    interpreter_mac #(
        .DW(DW),
        .WW(WW),
        .AW(AW)
    ) u_mac (
        .clk_i      (iClk),
        .rst_ni     (iRst_n),
        .clr_i      (clr),
        .vld_i      (vld_q),
        .state_i    (iState),
        .weight_i   (iWeight),
        .acc_next_o (acc_next)
    );

    // iss_q marks oAddr as a live read; the first RUN cycle only sets it,
    // so address k is presented during the cycle after edge E0+k+1.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            iss_q   <= 1'b0;
            vld_q   <= 1'b0;
            armed_q <= 1'b1;
            y_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            vld_q <= (state_q == S_RUN) && iss_q;
            rdy_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (iEn && armed_q) begin
                        state_q <= S_RUN;
                        addr_q  <= '0;
                        iss_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!iss_q) begin
                        iss_q <= 1'b1;
                    end else if (addr_q == AddrW'(N - 1)) begin
                        state_q <= S_DRAIN;
                        iss_q   <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + AddrW'(1);
                    end
                end
                S_DRAIN: begin
                    // Last product lands on this edge, so use the MAC's next value.
                    state_q <= S_DONE;
                    y_q     <= OW'(sat_s(64'(acc_next >>> SHIFT), OW));
                    rdy_q   <= 1'b1;
                end
                S_DONE: begin
                    armed_q <= 1'b0;
                    state_q <= S_REARM;
                end
                S_REARM: begin
                    if (!iEn) begin
                        armed_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oAddr = addr_q;
    assign oY    = y_q;
    assign oRdy  = rdy_q;

endmodule
